// File: rtl/clk_div_ratio_detector.sv
// Recovers the integer division ratio and high-phase length of a divided clock
// that is generated synchronously from the reference clock.
module clk_div_ratio_detector #(
   parameter int RATIO_W  = 8,
   parameter int LOCK_CNT = 2
) (
   input  logic               i_ref_clk,
   input  logic               i_rst,
   input  logic               i_clk_en,
   input  logic               i_div_clk,
   output logic [RATIO_W-1:0] o_ratio,
   output logic [RATIO_W-1:0] o_high_len,
   output logic               o_valid,
   output logic               o_err,
   output logic               o_stall
);

   localparam logic [RATIO_W-1:0] CNT_MAX = '1;
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);

   typedef enum logic [1:0] {IDLE, SYNC, MEASURE, LOCKED} state_t;

   state_t             state;
   logic               s0;
   logic               s1;
   logic               rise;
   logic [RATIO_W-1:0] p_cnt;
   logic [RATIO_W-1:0] h_cnt;
   logic [RATIO_W-1:0] last_p;
   logic [MATCH_W-1:0] match;

   assign rise = s0 & ~s1;

   // Both counters restart at 1 on a rising edge, so at the next rise they hold
   // the full period and the number of high cycles of the period just ended.
   always_ff @(posedge i_ref_clk) begin
      if (i_rst) begin
         s0    <= 1'b0;
         s1    <= 1'b0;
         p_cnt <= '0;
         h_cnt <= '0;
      end else begin
         s0 <= i_div_clk;
         s1 <= s0;
         if (rise) begin
            p_cnt <= RATIO_W'(1);
            h_cnt <= RATIO_W'(1);
         end else begin
            if (p_cnt != CNT_MAX)
               p_cnt <= p_cnt + 1'b1;
            if (s0 && (h_cnt != CNT_MAX))
               h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_ref_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         last_p     <= '0;
         match      <= '0;
         o_ratio    <= '0;
         o_high_len <= '0;
         o_valid    <= 1'b0;
         o_err      <= 1'b0;
         o_stall    <= 1'b0;
      end else begin
         o_err <= 1'b0;
         if (rise)
            o_stall <= 1'b0;
         if (!i_clk_en) begin
            state   <= IDLE;
            o_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: state <= SYNC;
               SYNC: begin
                  if (rise) begin
                     last_p <= '0;
                     match  <= '0;
                     state  <= MEASURE;
                  end
               end
               MEASURE: begin
                  if (rise) begin
                     if (p_cnt == last_p) begin
                        match <= match + 1'b1;
                        if (match == MATCH_LAST) begin
                           o_ratio    <= p_cnt;
                           o_high_len <= h_cnt;
                           o_valid    <= 1'b1;
                           state      <= LOCKED;
                        end
                     end else begin
                        match  <= '0;
                        last_p <= p_cnt;
                     end
                  end else if (p_cnt == CNT_MAX) begin
                     o_stall <= 1'b1;
                     o_valid <= 1'b0;
                     state   <= SYNC;
                  end
               end
               LOCKED: begin
                  // Any change of period or duty cycle drops lock and remeasures,
                  // seeding the new candidate period from this rise.
                  if (rise) begin
                     if ((p_cnt != o_ratio) || (h_cnt != o_high_len)) begin
                        o_err   <= 1'b1;
                        o_valid <= 1'b0;
                        last_p  <= p_cnt;
                        match   <= '0;
                        state   <= MEASURE;
                     end
                  end else if (p_cnt == CNT_MAX) begin
                     o_stall <= 1'b1;
                     o_valid <= 1'b0;
                     state   <= SYNC;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clk_div_ratio_detector.sv
// Directed self-checking bench: a behavioural divider drives the detector
// through lock, ratio changes, stalls, reset and enable drop.
module tb_clk_div_ratio_detector;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_en = 1'b0;
   logic       div_clk;
   logic [7:0] ratio_out;
   logic [7:0] high_out;
   logic       valid;
   logic       err;
   logic       stall;

   int   ratio = 4;
   logic div_level = 1'b0;
   int   div_cnt = 0;

   int   tests = 0;
   int   failed = 0;
   int   cyc = 0;
   int   err_count = 0;
   logic m_s0 = 1'b0;
   logic m_s1 = 1'b0;
   int   last_rise_cyc = 0;
   logic stall_prev = 1'b0;
   int   stall_cyc = 0;
   int   n;
   int   e0;

   clk_div_ratio_detector #(.RATIO_W(8), .LOCK_CNT(2)) dut (
      .i_ref_clk (clk),
      .i_rst     (rst),
      .i_clk_en  (clk_en),
      .i_div_clk (div_clk),
      .o_ratio   (ratio_out),
      .o_high_len(high_out),
      .o_valid   (valid),
      .o_err     (err),
      .o_stall   (stall)
   );

   always #5 clk = ~clk;

   // Divider model: high for floor(ratio/2) cycles; ratio below 2 holds a constant level.
   always @(posedge clk) begin
      if (ratio >= 2)
         div_cnt <= (div_cnt >= ratio - 1) ? 0 : div_cnt + 1;
      else
         div_cnt <= 0;
   end
   assign div_clk = (ratio >= 2) ? (div_cnt < ratio / 2) : div_level;

   // Edge index of the last sampled rise and of the first edge o_stall is seen set.
   always @(posedge clk) begin
      cyc        <= cyc + 1;
      m_s0       <= div_clk;
      m_s1       <= m_s0;
      stall_prev <= stall;
      if (m_s0 && !m_s1)
         last_rise_cyc <= cyc;
      if (err)
         err_count <= err_count + 1;
      if (stall && !stall_prev)
         stall_cyc <= cyc - 1;
   end

   task automatic check_output(input string tag, input int observed, input int expected);
      tests++;
      assert (observed === expected)
      else begin
         failed++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input int r, input logic lvl);
      @(negedge clk);
      ratio     = r;
      div_level = lvl;
   endtask

   task automatic wait_cycles(input int k);
      for (int i = 0; i < k; i++) @(negedge clk);
   endtask

   task automatic wait_valid(input int max_cycles, output int cycles);
      cycles = max_cycles + 1;
      for (int i = 1; i <= max_cycles; i++) begin
         @(negedge clk);
         if (valid) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic wait_drop(input int max_cycles, output int cycles);
      cycles = max_cycles + 1;
      for (int i = 1; i <= max_cycles; i++) begin
         @(negedge clk);
         if (!valid) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic wait_stall(input int max_cycles, output int cycles);
      cycles = max_cycles + 1;
      for (int i = 1; i <= max_cycles; i++) begin
         @(negedge clk);
         if (stall) begin
            cycles = i;
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      wait_cycles(3);
      rst = 1'b0;
      @(negedge clk);
      check_output("reset_valid", int'(valid), 0);
      check_output("reset_ratio", int'(ratio_out), 0);
      check_output("reset_high", int'(high_out), 0);
      check_output("reset_err", int'(err), 0);
      check_output("reset_stall", int'(stall), 0);

      // Ratio 4: lock within 20 cycles of enable, then stay clean for 40 cycles.
      clk_en = 1'b1;
      wait_valid(20, n);
      check_output("lock4_within_20", int'(n <= 20), 1);
      check_output("lock4_ratio", int'(ratio_out), 4);
      check_output("lock4_high", int'(high_out), 2);
      wait_cycles(40);
      check_output("lock4_still_valid", int'(valid), 1);
      check_output("lock4_no_err", err_count, 0);
      check_output("lock4_no_stall", int'(stall), 0);

      // Odd ratio 5 and the minimum period 2.
      apply_stimulus(5, 1'b0);
      wait_drop(30, n);
      check_output("r5_drop", int'(n <= 30), 1);
      wait_valid(60, n);
      check_output("r5_lock", int'(n <= 60), 1);
      check_output("r5_ratio", int'(ratio_out), 5);
      check_output("r5_high", int'(high_out), 2);
      apply_stimulus(2, 1'b0);
      wait_drop(30, n);
      wait_valid(60, n);
      check_output("r2_lock", int'(n <= 60), 1);
      check_output("r2_ratio", int'(ratio_out), 2);
      check_output("r2_high", int'(high_out), 1);

      // Locked at 4, switch to 6: exactly one error pulse, then relock.
      apply_stimulus(4, 1'b0);
      wait_drop(30, n);
      wait_valid(60, n);
      check_output("r4_relock_ratio", int'(ratio_out), 4);
      wait_cycles(3);
      e0 = err_count;
      apply_stimulus(6, 1'b0);
      wait_drop(30, n);
      check_output("r6_valid_low", int'(valid), 0);
      wait_valid(60, n);
      check_output("r6_lock", int'(n <= 60), 1);
      wait_cycles(2);
      check_output("r6_err_pulses", err_count - e0, 1);
      check_output("r6_ratio", int'(ratio_out), 6);
      check_output("r6_high", int'(high_out), 3);

      // Stopped clock (held low): stall exactly 255 cycles after last rise.
      apply_stimulus(0, 1'b0);
      wait_stall(400, n);
      check_output("stop_stall_seen", int'(n <= 400), 1);
      @(negedge clk);
      check_output("stop_stall_delay", stall_cyc - last_rise_cyc, 255);
      check_output("stop_valid_low", int'(valid), 0);
      check_output("stop_ratio_hold", int'(ratio_out), 6);

      // Restart at 4 clears stall, then bypass (held high) stalls again.
      apply_stimulus(4, 1'b0);
      wait_valid(60, n);
      check_output("restart_lock", int'(n <= 60), 1);
      check_output("restart_stall_clear", int'(stall), 0);
      check_output("restart_ratio", int'(ratio_out), 4);
      apply_stimulus(1, 1'b1);
      wait_stall(400, n);
      check_output("bypass_stall_seen", int'(n <= 400), 1);
      @(negedge clk);
      check_output("bypass_stall_delay", stall_cyc - last_rise_cyc, 255);
      check_output("bypass_valid_low", int'(valid), 0);
      check_output("bypass_ratio_hold", int'(ratio_out), 4);

      // Reset while locked at 8.
      apply_stimulus(8, 1'b0);
      wait_valid(80, n);
      check_output("r8_lock", int'(n <= 80), 1);
      check_output("r8_ratio", int'(ratio_out), 8);
      check_output("r8_high", int'(high_out), 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_output("mid_reset_valid", int'(valid), 0);
      check_output("mid_reset_ratio", int'(ratio_out), 0);
      check_output("mid_reset_high", int'(high_out), 0);
      check_output("mid_reset_stall", int'(stall), 0);
      check_output("mid_reset_err", int'(err), 0);
      wait_valid(60, n);
      check_output("r8_relock", int'(n <= 60), 1);
      check_output("r8_relock_ratio", int'(ratio_out), 8);

      // Enable dropped while locked: valid low next cycle, ratio held, no error.
      wait_cycles(3);
      e0 = err_count;
      clk_en = 1'b0;
      @(negedge clk);
      check_output("dis_valid_low", int'(valid), 0);
      check_output("dis_ratio_hold", int'(ratio_out), 8);
      wait_cycles(20);
      check_output("dis_no_err", err_count - e0, 0);
      clk_en = 1'b1;
      wait_valid(60, n);
      check_output("reen_lock", int'(n <= 60), 1);
      check_output("reen_ratio", int'(ratio_out), 8);
      check_output("reen_high", int'(high_out), 4);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
